// File: rtl/sha256_result_check_if.sv
// Result bus between the SHA-256 round pipeline, the result checker and
// the downstream hit consumer. The checker uses the slave modport.
interface sha256_result_check_if;
  logic        in_valid;
  logic [31:0] in_reg_a;
  logic [31:0] in_reg_b;
  logic [31:0] in_reg_c;
  logic [31:0] in_reg_d;
  logic [31:0] in_reg_e;
  logic [31:0] in_reg_f;
  logic [31:0] in_reg_g;
  logic [31:0] in_reg_h;
  logic [31:0] in_nonce;

  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_nonce;
  logic [255:0] out_digest;

  modport slave (
    input  in_valid, in_reg_a, in_reg_b, in_reg_c, in_reg_d,
           in_reg_e, in_reg_f, in_reg_g, in_reg_h, in_nonce, out_ready,
    output out_valid, out_nonce, out_digest
  );

  modport master (
    output in_valid, in_reg_a, in_reg_b, in_reg_c, in_reg_d,
           in_reg_e, in_reg_f, in_reg_g, in_reg_h, in_nonce, out_ready,
    input  out_valid, out_nonce, out_digest
  );
endinterface

// File: rtl/sha256_result_check.sv
// SHA-256 result checker: adds the chaining value to the final-round
// working registers, compares the digest against a target and queues
// hits (nonce, optionally digest) in a small FIFO with drop counting.
//
// Build option: define SHA256_RESULT_DIGEST_EN to store the 256-bit
// digest alongside the nonce and present it on out_digest. Without it
// only the nonce is stored and out_digest is tied to zero.
//
// FIFO_DEPTH must be a power of two in the range 2..16.
module sha256_result_check #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_result_check_if.slave  res,
  input  logic [255:0]          in_hash_init,
  input  logic [255:0]          in_target,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
`ifdef SHA256_RESULT_DIGEST_EN
  localparam int EW = 288;
`else
  localparam int EW = 32;
`endif

  // Stage 1: digest words and nonce
  logic         s1_valid_q, s1_valid_d;
  logic [255:0] s1_digest_q, s1_digest_d;
  logic [31:0]  s1_nonce_q, s1_nonce_d;

  // Stage 2: compare result
  logic         s2_hit_q, s2_hit_d;
  logic [31:0]  s2_nonce_q, s2_nonce_d;
`ifdef SHA256_RESULT_DIGEST_EN
  logic [255:0] s2_digest_q, s2_digest_d;
`endif

  // FIFO state
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];

  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;

  // Stage 1 next state: data only loads on a valid result so idle inputs never disturb state
  always_comb begin
    s1_valid_d  = res.in_valid;
    s1_digest_d = s1_digest_q;
    s1_nonce_d  = s1_nonce_q;
    if (res.in_valid) begin
      s1_digest_d = {in_hash_init[255:224] + res.in_reg_a,
                     in_hash_init[223:192] + res.in_reg_b,
                     in_hash_init[191:160] + res.in_reg_c,
                     in_hash_init[159:128] + res.in_reg_d,
                     in_hash_init[127:96]  + res.in_reg_e,
                     in_hash_init[95:64]   + res.in_reg_f,
                     in_hash_init[63:32]   + res.in_reg_g,
                     in_hash_init[31:0]    + res.in_reg_h};
      s1_nonce_d  = res.in_nonce;
    end
  end

  // Stage 2 next state: full-width unsigned compare against the target
  always_comb begin
    s2_hit_d   = s1_valid_q && (s1_digest_q <= in_target);
    s2_nonce_d = s2_nonce_q;
`ifdef SHA256_RESULT_DIGEST_EN
    s2_digest_d = s2_digest_q;
`endif
    if (s1_valid_q) begin
      s2_nonce_d = s1_nonce_q;
`ifdef SHA256_RESULT_DIGEST_EN
      s2_digest_d = s1_digest_q;
`endif
    end
  end

  // FIFO status; a pop frees the slot a same-cycle push into a full FIFO writes
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && res.out_ready;
    push_ok    = s2_hit_q && (!fifo_full || pop);
    drop       = s2_hit_q && fifo_full && !pop;
`ifdef SHA256_RESULT_DIGEST_EN
    push_entry = {s2_nonce_q, s2_digest_q};
`else
    push_entry = s2_nonce_q;
`endif
  end

  // Pointer and drop counter next state; counter saturates at all-ones
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_count_d = drop_count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  // Storage next state: write the hit at the write pointer slot
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_entry;
  end

  // Head presentation; zero while empty so stale storage never shows
  always_comb begin
    head_entry     = mem_q[rd_ptr_q[AW-1:0]];
    res.out_valid  = !fifo_empty;
    res.out_nonce  = fifo_empty ? 32'd0 : head_entry[EW-1 -: 32];
`ifdef SHA256_RESULT_DIGEST_EN
    res.out_digest = fifo_empty ? 256'd0 : head_entry[255:0];
`else
    res.out_digest = 256'd0;
`endif
    drop_count     = drop_count_q;
  end

  // Control state with asynchronous clear; in-flight results are discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_digest_q  <= '0;
      s1_nonce_q   <= '0;
      s2_hit_q     <= 1'b0;
      s2_nonce_q   <= '0;
`ifdef SHA256_RESULT_DIGEST_EN
      s2_digest_q  <= '0;
`endif
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_digest_q  <= s1_digest_d;
      s1_nonce_q   <= s1_nonce_d;
      s2_hit_q     <= s2_hit_d;
      s2_nonce_q   <= s2_nonce_d;
`ifdef SHA256_RESULT_DIGEST_EN
      s2_digest_q  <= s2_digest_d;
`endif
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

  // FIFO storage needs no reset: contents are only visible through valid pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sha256_result_check.sv
// Self-checking bench for sha256_result_check (default FIFO_DEPTH = 4).
// A queue-level reference model predicts which results are hits and the
// order in which they must leave the FIFO; the digest check follows the
// SHA256_RESULT_DIGEST_EN build option.
module tb_sha256_result_check;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0]  nonce;
    logic [255:0] digest;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] hash_init;
  logic [255:0] target;
  logic [15:0]  drop_count;

  int checks = 0;
  int errors = 0;

  entry_t      model_q[$];
  int          exp_drops;
  bit          hold_ready;
  logic [31:0] regs [8];

  sha256_result_check_if bus ();

  sha256_result_check #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res          (bus),
    .in_hash_init (hash_init),
    .in_target    (target),
    .drop_count   (drop_count)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Digest from the hashing rule: word-wise addition modulo 2^32
  function automatic logic [255:0] ref_digest(input logic [255:0] h, input logic [31:0] r [8]);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] hw;
      hw = h[255 - 32*i -: 32];
      d[255 - 32*i -: 32] = hw + r[i];
    end
    return d;
  endfunction

  // What out_digest should show for a stored digest in this build
  function automatic logic [255:0] exp_digest(input logic [255:0] d);
`ifdef SHA256_RESULT_DIGEST_EN
    return d;
`else
    return (d & 256'd0);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the visible head against the model, retire it on a pop, advance one cycle
  task automatic step();
    if (bus.out_valid === 1'b1) begin
      checkOutput("head_expected", {255'd0, model_q.size() != 0}, 256'd1);
      if (model_q.size() != 0) begin
        checkOutput("head_nonce", {224'd0, bus.out_nonce}, {224'd0, model_q[0].nonce});
        checkOutput("head_digest", bus.out_digest, exp_digest(model_q[0].digest));
        if (bus.out_ready === 1'b1) void'(model_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  // Drive one valid result for a cycle and record its predicted fate
  task automatic applyStimulus(input logic [31:0] nonce);
    logic [255:0] d;
    d = ref_digest(hash_init, regs);
    bus.in_valid = 1'b1;
    bus.in_reg_a = regs[0];
    bus.in_reg_b = regs[1];
    bus.in_reg_c = regs[2];
    bus.in_reg_d = regs[3];
    bus.in_reg_e = regs[4];
    bus.in_reg_f = regs[5];
    bus.in_reg_g = regs[6];
    bus.in_reg_h = regs[7];
    bus.in_nonce = nonce;
    if (d <= target) begin
      if (!hold_ready || model_q.size() < DEPTH) model_q.push_back('{nonce, d});
      else exp_drops++;
    end
    step();
  endtask

  // Idle cycles with garbage on the data inputs
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      bus.in_reg_a = $urandom;
      bus.in_reg_b = $urandom;
      bus.in_reg_h = $urandom;
      bus.in_nonce = $urandom;
      step();
    end
  endtask

  task automatic randomRegs();
    for (int i = 0; i < 8; i++) regs[i] = $urandom;
  endtask

  // Pop everything with a bounded cycle budget; returns the number of pops
  task automatic drain(input int budget, output int pops);
    pops = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < budget && (model_q.size() != 0 || bus.out_valid === 1'b1); i++) begin
      if (bus.out_valid === 1'b1) pops++;
      step();
    end
    checkOutput("drain_model_empty", model_q.size(), 256'd0);
    checkOutput("drain_out_valid", {255'd0, bus.out_valid}, 256'd0);
  endtask

  initial begin
    logic [255:0] d;
    logic [255:0] dx;
    logic [31:0]  w;
    int           pops;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_reg_a  = '0; bus.in_reg_b = '0; bus.in_reg_c = '0; bus.in_reg_d = '0;
    bus.in_reg_e  = '0; bus.in_reg_f = '0; bus.in_reg_g = '0; bus.in_reg_h = '0;
    bus.in_nonce  = '0;
    hash_init     = '0;
    target        = '0;
    exp_drops     = 0;
    hold_ready    = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", {255'd0, bus.out_valid}, 256'd0);
    checkOutput("reset_drop_count", {240'd0, drop_count}, 256'd0);
    checkOutput("reset_out_nonce", {224'd0, bus.out_nonce}, 256'd0);
    checkOutput("reset_out_digest", bus.out_digest, 256'd0);

    // Wrap case, driven on the first edge after reset release; 3-cycle latency
    $display("[TB] wrap and latency");
    rst_n     = 1'b1;
    target    = '1;
    hash_init = {32'hFFFFFFFF, 224'd0};
    regs[0]   = 32'h00000002;
    applyStimulus(32'h12345678);
    checkOutput("lat_cycle1", {255'd0, bus.out_valid}, 256'd0);
    idle(1);
    checkOutput("lat_cycle2", {255'd0, bus.out_valid}, 256'd0);
    idle(1);
    checkOutput("lat_cycle3", {255'd0, bus.out_valid}, 256'd1);
    checkOutput("wrap_nonce", {224'd0, bus.out_nonce}, {224'd0, 32'h12345678});
    dx = exp_digest({32'h00000001, 224'd0});
    w  = bus.out_digest[255:224];
    checkOutput("wrap_digest_h0", {224'd0, w}, {224'd0, dx[255:224]});
    checkOutput("wrap_digest_full", bus.out_digest, dx);
    idle(2);
    drain(20, pops);
    checkOutput("wrap_pops", pops, 256'd1);

    // Boundary: digest equal to target hits, target one below misses
    $display("[TB] compare boundaries");
    hash_init = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    randomRegs();
    d = ref_digest(hash_init, regs);
    target = d;
    bus.out_ready = 1'b0;
    applyStimulus(32'hB0B0_0001);
    idle(3);
    checkOutput("equal_hit_valid", {255'd0, bus.out_valid}, 256'd1);
    drain(20, pops);
    checkOutput("equal_hit_pops", pops, 256'd1);
    target = d - 256'd1;
    applyStimulus(32'hB0B0_0002);
    idle(5);
    checkOutput("above_target_valid", {255'd0, bus.out_valid}, {255'd0, d == 256'd0});
    drain(20, pops);

    // Random back-to-back traffic at full throughput with a consumer always ready
    $display("[TB] random throughput");
    target = {32'h80000000, 224'd0};
    bus.out_ready = 1'b1;
    for (int n = 0; n < 32; n++) begin
      hash_init = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      randomRegs();
      applyStimulus($urandom);
    end
    drain(20, pops);
    checkOutput("random_no_drops", {240'd0, drop_count}, 256'd0);

    // Overflow: six hits into a stalled FIFO keep the first four
    $display("[TB] overflow");
    target        = '1;
    bus.out_ready = 1'b0;
    hold_ready    = 1'b1;
    for (int n = 0; n < 6; n++) begin
      randomRegs();
      applyStimulus(32'hA000_0000 + n);
    end
    idle(4);
    checkOutput("overflow_drop_count", {240'd0, drop_count}, exp_drops);
    checkOutput("overflow_drop_two", {240'd0, drop_count}, 256'd2);
    checkOutput("overflow_head", {224'd0, bus.out_nonce}, {224'd0, 32'hA0000000});

    // Full FIFO with push and pop on the same edge: no drop, head advances
    $display("[TB] full with simultaneous pop");
    hold_ready = 1'b0;
    randomRegs();
    applyStimulus(32'hB000_0000);
    idle(1);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    idle(1);
    checkOutput("fullpop_drop_count", {240'd0, drop_count}, 256'd2);
    checkOutput("fullpop_head", {224'd0, bus.out_nonce}, {224'd0, 32'hA0000001});
    drain(20, pops);
    checkOutput("fullpop_remaining", pops, 256'd4);

    // Reset one cycle after a hit enters: nothing comes out afterwards
    $display("[TB] mid-operation reset");
    target = '1;
    bus.out_ready = 1'b1;
    randomRegs();
    applyStimulus(32'hC000_0000);
    rst_n = 1'b0;
    model_q.delete();
    exp_drops = 0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("reset_flush_valid", {255'd0, bus.out_valid}, 256'd0);
      idle(1);
    end
    checkOutput("reset_flush_drops", {240'd0, drop_count}, 256'd0);

    // Recovery after reset
    randomRegs();
    applyStimulus(32'hD000_0000);
    drain(20, pops);
    checkOutput("recover_pops", pops, 256'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_result_check.md
SHA256_RESULT_CHECK -- requirements
Module: sha256_result_check

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, hit FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports in_reg_a..in_reg_h  input  32 each  working registers leaving the final (64th) round stage.
REQ-005 SHALL have port in_valid  input  1  qualifies in_reg_a..h and in_nonce this cycle; no backpressure.
REQ-006 SHALL have port in_nonce  input  32  nonce tagged to the incoming result.
REQ-007 SHALL have port in_hash_init  input  256  chaining value H0..H7; H0 in bits [255:224].
REQ-008 SHALL have port in_target  input  256  unsigned threshold; quasi-static, sampled at the compare stage.
REQ-009 SHALL have port out_valid  output  1  FIFO head valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head when high with out_valid.
REQ-011 SHALL have port out_nonce  output  32  nonce of FIFO head.
REQ-012 SHALL have port out_digest  output  256  digest of FIFO head; H0' in [255:224].
REQ-013 SHALL have port drop_count  output  16  count of hits lost to a full FIFO.

Function
REQ-014 SHALL, in stage 1, register digest word i = H_i + reg_i modulo 2^32 (a..h to H0..H7), and register in_nonce and in_valid alongside.
REQ-015 SHALL, in stage 2, register hit = stage-1 valid AND (digest <= in_target) as a 256-bit unsigned compare.
REQ-016 SHALL write {nonce, digest} into the FIFO the cycle after stage 2 asserts hit; in_valid to out_valid latency is 3 cycles when the FIFO is empty.
REQ-017 SHALL pop the head on any cycle with out_valid and out_ready both high.
REQ-018 SHALL hold out_nonce and out_digest stable while out_valid is high and out_ready is low.
REQ-019 SHALL accept a push on a cycle with a simultaneous pop, even when the FIFO is full.
REQ-020 SHALL drop the hit and increment drop_count on a push when full without a pop.
REQ-021 SHALL saturate drop_count at 0xFFFF.
REQ-022 SHALL, when the FIFO is empty, not forward a same-cycle push combinationally; out_valid rises the following cycle.
REQ-023 SHALL use read and write pointers of log2(FIFO_DEPTH)+1 bits that wrap naturally, with full/empty derived from them.
REQ-024 SHALL accept back-to-back in_valid every cycle at full throughput.
REQ-025 SHALL ignore in_reg_*, in_nonce and in_hash_init when in_valid is low, with no state change.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear both stage valids, FIFO pointers and drop_count, giving out_valid=0 and drop_count=0.
REQ-027 SHALL drive out_nonce=0 and out_digest=0 while the FIFO is empty after reset.
REQ-028 SHALL discard results in flight when reset is asserted mid-operation; none appear after release.
REQ-029 SHALL accept in_valid on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with SHA256_RESULT_DIGEST_EN defined, store the 256-bit digest in the FIFO and present it on out_digest.
REQ-031 SHALL, without SHA256_RESULT_DIGEST_EN, store only the nonce and tie out_digest to 0; the compare is unaffected.

Verification
REQ-032 SHALL cover wrap: H0=0xFFFFFFFF, reg_a=0x00000002, other words 0, target all-ones, nonce 0x12345678 -> 3 cycles later out_valid=1, out_nonce=0x12345678, out_digest[255:224]=0x00000001.
REQ-033 SHALL cover boundaries: digest equal to target -> hit; digest = target+1 -> no push, out_valid stays 0.
REQ-034 SHALL cover overflow: FIFO_DEPTH=4, out_ready=0, six consecutive hits -> 4 entries held, drop_count=2, then drain returns the first four nonces in order.
REQ-035 SHALL cover full with simultaneous pop: a full FIFO with push and pop in the same cycle -> no drop, count stays 4, head advances.
REQ-036 SHALL cover mid-operation reset: rst_n pulsed low 1 cycle after in_valid -> out_valid never rises, drop_count=0.
REQ-037 SHALL cover build without SHA256_RESULT_DIGEST_EN: the scenario of REQ-032 -> out_nonce=0x12345678 and out_digest=0.
